// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, widths, NOP encoding
// and the default reset PC used by the fetch, decode and execute stages.
package cpu_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned SHAMT_W  = 5;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JADDR_W  = 26;

  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned JADDR_LSB  = 0;

  localparam logic [XLEN-1:0] NOP              = '0;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-align an address by clearing its byte-offset bits.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: synchronous reset, redirect load, and enabled +4 increment.
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= word_align(target);
    end else if (inc_en) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch and IF/ID pipeline register with stall backpressure,
// one-bubble redirect flush and decode-field slicing.
module if_id_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                id_ready,
  input  logic                br_taken,
  input  logic [XLEN-1:0]     br_target,
  output logic                id_valid,
  output logic [XLEN-1:0]     id_instr,
  output logic [XLEN-1:0]     id_pc,
  output logic [XLEN-1:0]     id_pc_plus4,
  output logic [OPCODE_W-1:0] id_opcode,
  output logic [REG_W-1:0]    id_rs,
  output logic [REG_W-1:0]    id_rt,
  output logic [REG_W-1:0]    id_rd,
  output logic [SHAMT_W-1:0]  id_shamt,
  output logic [FUNCT_W-1:0]  id_funct,
  output logic [IMM_W-1:0]    id_imm16,
  output logic [JADDR_W-1:0]  id_jaddr
);

  logic            adv;
  logic [XLEN-1:0] pc;

  // An empty register always accepts, so a bubble never blocks fetch.
  assign adv = id_ready | ~id_valid;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .reset_n  (reset_n),
    .redirect (br_taken),
    .target   (br_target),
    .inc_en   (adv),
    .pc       (pc)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
      id_pc    <= '0;
    end else if (br_taken) begin
      id_valid <= 1'b0;
      id_instr <= NOP;
    end else if (adv) begin
      id_valid <= 1'b1;
      id_instr <= imem_rdata;
      id_pc    <= pc;
    end
  end

  assign id_pc_plus4 = id_pc + 32'd4;

  assign id_opcode = id_instr[OPCODE_LSB +: OPCODE_W];
  assign id_rs     = id_instr[RS_LSB     +: REG_W];
  assign id_rt     = id_instr[RT_LSB     +: REG_W];
  assign id_rd     = id_instr[RD_LSB     +: REG_W];
  assign id_shamt  = id_instr[SHAMT_LSB  +: SHAMT_W];
  assign id_funct  = id_instr[FUNCT_LSB  +: FUNCT_W];
  assign id_imm16  = id_instr[IMM_LSB    +: IMM_W];
  assign id_jaddr  = id_instr[JADDR_LSB  +: JADDR_W];

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: reset, field split, stall, redirect,
// back-to-back redirects, PC wrap and reset during stall/redirect.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [25:0] id_jaddr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  if_id_stage #(
    .RESET_PC (32'h0040_0000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_shamt    (id_shamt),
    .id_funct    (id_funct),
    .id_imm16    (id_imm16),
    .id_jaddr    (id_jaddr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    id_ready   = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    imem_rdata = 32'h0;

    // Reset held for two edges
    step();
    step();
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_addr",  imem_addr, 32'h0040_0000);
    check("rst_instr", id_instr,  32'h0);
    check("rst_pc",    id_pc,     32'h0);
    check("rst_op",    {26'b0, id_opcode}, 32'h0);

    // First fetch, lw $9,-4($8)
    reset_n    = 1'b1;
    imem_rdata = 32'h8D09_FFFC;
    step();
    check("ff_valid",  {31'b0, id_valid}, 32'h1);
    check("ff_pc",     id_pc,       32'h0040_0000);
    check("ff_pc4",    id_pc_plus4, 32'h0040_0004);
    check("ff_addr",   imem_addr,   32'h0040_0004);
    check("ff_instr",  id_instr,    32'h8D09_FFFC);
    check("f_opcode",  {26'b0, id_opcode}, 32'h23);
    check("f_rs",      {27'b0, id_rs},     32'd8);
    check("f_rt",      {27'b0, id_rt},     32'd9);
    check("f_rd",      {27'b0, id_rd},     32'd31);
    check("f_shamt",   {27'b0, id_shamt},  32'd31);
    check("f_funct",   {26'b0, id_funct},  32'h3C);
    check("f_imm16",   {16'b0, id_imm16},  32'h0000_FFFC);
    check("f_jaddr",   {6'b0, id_jaddr},   32'h0109_FFFC);

    // Stall three cycles
    id_ready   = 1'b0;
    imem_rdata = 32'h0123_4567;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_valid", {31'b0, id_valid}, 32'h1);
      check("st_instr", id_instr,  32'h8D09_FFFC);
      check("st_pc",    id_pc,     32'h0040_0000);
      check("st_addr",  imem_addr, 32'h0040_0004);
    end

    // Resume: next sequential PC, nothing skipped
    id_ready = 1'b1;
    step();
    check("rs_instr", id_instr,  32'h0123_4567);
    check("rs_pc",    id_pc,     32'h0040_0004);
    check("rs_addr",  imem_addr, 32'h0040_0008);

    // Redirect wins over stall; target low bits dropped
    id_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h0000_1003;
    step();
    check("br_valid", {31'b0, id_valid}, 32'h0);
    check("br_addr",  imem_addr, 32'h0000_1000);
    check("br_instr", id_instr,  32'h0);
    check("br_rt",    {27'b0, id_rt}, 32'h0);

    // Bubble accepted even with id_ready low
    br_taken   = 1'b0;
    imem_rdata = 32'hAABB_CCDD;
    step();
    check("bt_valid", {31'b0, id_valid}, 32'h1);
    check("bt_pc",    id_pc,     32'h0000_1000);
    check("bt_instr", id_instr,  32'hAABB_CCDD);
    check("bt_addr",  imem_addr, 32'h0000_1004);

    // Now a real stall again
    imem_rdata = 32'h1111_2222;
    step();
    check("s2_instr", id_instr,  32'hAABB_CCDD);
    check("s2_addr",  imem_addr, 32'h0000_1004);

    // Back-to-back redirects: last target wins
    id_ready  = 1'b1;
    br_taken  = 1'b1;
    br_target = 32'h0000_2000;
    step();
    br_target = 32'h0000_3009;
    step();
    check("bb_addr",  imem_addr, 32'h0000_3008);
    check("bb_valid", {31'b0, id_valid}, 32'h0);
    br_taken   = 1'b0;
    imem_rdata = 32'h3333_4444;
    step();
    check("bb_pc",    id_pc,     32'h0000_3008);
    check("bb_instr", id_instr,  32'h3333_4444);

    // PC wrap
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFF;
    step();
    check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    br_taken   = 1'b0;
    imem_rdata = 32'h5555_6666;
    step();
    check("wr_pc",    id_pc,       32'hFFFF_FFFC);
    check("wr_pc4",   id_pc_plus4, 32'h0000_0000);
    check("wr_addr",  imem_addr,   32'h0000_0000);

    // Reset mid-stall
    id_ready = 1'b0;
    reset_n  = 1'b0;
    step();
    check("rm_valid", {31'b0, id_valid}, 32'h0);
    check("rm_instr", id_instr,  32'h0);
    check("rm_addr",  imem_addr, 32'h0040_0000);
    check("rm_pc",    id_pc,     32'h0);

    // Reset overrides a concurrent redirect
    br_taken  = 1'b1;
    br_target = 32'h0000_8000;
    step();
    check("rb_addr",  imem_addr, 32'h0040_0000);

    // Clean restart
    br_taken   = 1'b0;
    reset_n    = 1'b1;
    id_ready   = 1'b1;
    imem_rdata = 32'h7777_8888;
    step();
    check("rr_valid", {31'b0, id_valid}, 32'h1);
    check("rr_pc",    id_pc,     32'h0040_0000);
    check("rr_addr",  imem_addr, 32'h0040_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
